decode_stage: RTL and testbench

- RV32I decode stage; sits between fetch and execute.
- Drives the register file read addresses combinationally from the incoming instruction and captures the returned operands into the decode/execute pipeline register.
- Decodes the instruction class, immediate and destination register.
- Detects load-use hazards against the instruction currently held in its own output register, and inserts a bubble when one is found.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/decode_imm.sv | 47 ++++
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I decode definitions: base opcodes, the instruction class code
//   carried down the pipeline, and the immediate-format selector.
//   No ports.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        BRANCH = 3'd3,
        JAL    = 3'd4,
        JALR   = 3'd5,
        LUI    = 3'd6,
        AUIPC  = 3'd7
    } op_class_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

endpackage

// File: rtl/decode_imm.sv
// -----------------------------------------------------------------------------
// decode_imm
//   Purely combinational immediate extraction for 32-bit RV32I encodings.
//   Ports:
//     inst_i  in  32  raw instruction word
//     fmt_o   out 3   immediate format (imm_fmt_t encoding)
//     imm_o   out 32  sign-extended immediate, 0 when the format is IMM_NONE
// -----------------------------------------------------------------------------
module decode_imm
    import riscv_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [2:0]  fmt_o,
    output logic [31:0] imm_o
);

    imm_fmt_t fmt_s;

    // Every base opcode ends in 2'b11, so a word with any other low bits
    // falls through to IMM_NONE without a separate check.
    always_comb begin
        case (inst_i[6:0])
            OPC_LUI, OPC_AUIPC:              fmt_s = IMM_U;
            OPC_JAL:                         fmt_s = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:  fmt_s = IMM_I;
            OPC_STORE:                       fmt_s = IMM_S;
            OPC_BRANCH:                      fmt_s = IMM_B;
            default:                         fmt_s = IMM_NONE;
        endcase
    end

    always_comb begin
        case (fmt_s)
            IMM_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U:   imm_o = {inst_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

    assign fmt_o = fmt_s;

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage between fetch and execute. Register-file addresses are
//   driven straight from the incoming word; operands, immediate, class and
//   destination are captured into the decode/execute register. A load held in
//   the output register whose rd feeds the incoming instruction causes one
//   bubble (decode_stall).
//
//   Handshake: fetch presents fetch_valid/fetch_pc/fetch_instruction and must
//   hold them unchanged in any cycle where decode_stall=1. The instruction is
//   consumed on a rising edge with stall=0, flush=0, decode_stall=0. exe_valid
//   marks the output register as a real instruction; while stall=1 every exe_*
//   output holds. flush kills both the incoming and the held instruction and
//   takes priority over stall.
//
//   Ports:
//     clk, reset                       clock, async active-high reset
//     fetch_valid/pc/instruction       incoming instruction
//     decode_stall                     combinational load-use stall to fetch
//     stall, flush                     downstream hold / kill
//     rs1_address, rs2_address         to regfile
//     rs1_data, rs2_data               from regfile
//     exe_*                            decode/execute pipeline register
// -----------------------------------------------------------------------------
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instruction,
    output logic        decode_stall,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  rs1_address,
    output logic [4:0]  rs2_address,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        exe_valid,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_rs1_data,
    output logic [31:0] exe_rs2_data,
    output logic [31:0] exe_imm,
    output logic [4:0]  exe_rd_address,
    output logic [2:0]  exe_op_class,
    output logic [2:0]  exe_funct3,
    output logic        exe_funct7_5,
    output logic        exe_illegal
);

    // ---------------- combinational decode ----------------
    logic [6:0]  opcode;
    logic [2:0]  fmt;
    logic [31:0] imm_dec;
    logic        legal, is_op, rs1_used, rs2_used, rd_written, f75_dec;
    op_class_t   cls_dec;
    logic [4:0]  rd_dec;

    assign opcode      = fetch_instruction[6:0];
    assign rs1_address = fetch_instruction[19:15];
    assign rs2_address = fetch_instruction[24:20];

    decode_imm u_imm (
        .inst_i (fetch_instruction),
        .fmt_o  (fmt),
        .imm_o  (imm_dec)
    );

    always_comb begin
        legal   = 1'b1;
        cls_dec = ALU;
        case (opcode)
            OPC_LUI:            cls_dec = LUI;
            OPC_AUIPC:          cls_dec = AUIPC;
            OPC_JAL:            cls_dec = JAL;
            OPC_JALR:           cls_dec = JALR;
            OPC_BRANCH:         cls_dec = BRANCH;
            OPC_LOAD:           cls_dec = LOAD;
            OPC_STORE:          cls_dec = STORE;
            OPC_OP_IMM, OPC_OP: cls_dec = ALU;
            default:            legal   = 1'b0;
        endcase
    end

    // OP has no immediate, so register usage and rd presence follow from the
    // immediate format plus an explicit OP term. Illegal words use nothing.
    assign is_op      = (opcode == OPC_OP);
    assign rs1_used   = is_op || (fmt == IMM_I) || (fmt == IMM_S) || (fmt == IMM_B);
    assign rs2_used   = is_op || (fmt == IMM_S) || (fmt == IMM_B);
    assign rd_written = is_op || (fmt == IMM_I) || (fmt == IMM_U) || (fmt == IMM_J);
    assign rd_dec     = rd_written ? fetch_instruction[11:7] : 5'd0;

    // funct7[5] is meaningful for OP and for the OP-IMM shifts (funct3 x01).
    assign f75_dec = fetch_instruction[30] &&
                     (is_op || ((opcode == OPC_OP_IMM) && (fetch_instruction[13:12] == 2'b01)));

    // ---------------- pipeline register ----------------
    logic        valid_q,  valid_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] rs1d_q,   rs1d_d;
    logic [31:0] rs2d_q,   rs2d_d;
    logic [31:0] imm_q,    imm_d;
    logic [4:0]  rd_q,     rd_d;
    op_class_t   cls_q,    cls_d;
    logic [2:0]  f3_q,     f3_d;
    logic        f75_q,    f75_d;
    logic        ill_q,    ill_d;

    // Load-use: the held load's rd feeds a source the incoming word reads.
    assign decode_stall = fetch_valid && valid_q && (cls_q == LOAD) && (rd_q != 5'd0) &&
                          ((rs1_used && (rs1_address == rd_q)) ||
                           (rs2_used && (rs2_address == rd_q)));

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1d_d  = rs1d_q;
        rs2d_d  = rs2d_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        cls_d   = cls_q;
        f3_d    = f3_q;
        f75_d   = f75_q;
        ill_d   = ill_q;
        if (flush) begin
            valid_d = 1'b0;
            rd_d    = 5'd0;
            ill_d   = 1'b0;
        end else if (!stall) begin
            if (decode_stall) begin
                // Bubble; the held word is decoded again next cycle.
                valid_d = 1'b0;
                rd_d    = 5'd0;
            end else begin
                valid_d = fetch_valid;
                pc_d    = fetch_pc;
                rs1d_d  = rs1_data;
                rs2d_d  = rs2_data;
                imm_d   = imm_dec;
                rd_d    = fetch_valid ? rd_dec : 5'd0;
                cls_d   = cls_dec;
                f3_d    = fetch_instruction[14:12];
                f75_d   = f75_dec;
                ill_d   = fetch_valid && !legal;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            rs1d_q  <= 32'd0;
            rs2d_q  <= 32'd0;
            imm_q   <= 32'd0;
            rd_q    <= 5'd0;
            cls_q   <= ALU;
            f3_q    <= 3'd0;
            f75_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1d_q  <= rs1d_d;
            rs2d_q  <= rs2d_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            cls_q   <= cls_d;
            f3_q    <= f3_d;
            f75_q   <= f75_d;
            ill_q   <= ill_d;
        end
    end

    assign exe_valid      = valid_q;
    assign exe_pc         = pc_q;
    assign exe_rs1_data   = rs1d_q;
    assign exe_rs2_data   = rs2d_q;
    assign exe_imm        = imm_q;
    assign exe_rd_address = rd_q;
    assign exe_op_class   = cls_q;
    assign exe_funct3     = f3_q;
    assign exe_funct7_5   = f75_q;
    assign exe_illegal    = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int EXP_W = 142;
    localparam int NVEC  = 14;

    logic        clk, reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc, fetch_instruction;
    logic        decode_stall, stall, flush;
    logic [4:0]  rs1_address, rs2_address;
    logic [31:0] rs1_data, rs2_data;
    logic        exe_valid;
    logic [31:0] exe_pc, exe_rs1_data, exe_rs2_data, exe_imm;
    logic [4:0]  exe_rd_address;
    logic [2:0]  exe_op_class, exe_funct3;
    logic        exe_funct7_5, exe_illegal;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_instruction (fetch_instruction),
        .decode_stall      (decode_stall),
        .stall             (stall),
        .flush             (flush),
        .rs1_address       (rs1_address),
        .rs2_address       (rs2_address),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .exe_valid         (exe_valid),
        .exe_pc            (exe_pc),
        .exe_rs1_data      (exe_rs1_data),
        .exe_rs2_data      (exe_rs2_data),
        .exe_imm           (exe_imm),
        .exe_rd_address    (exe_rd_address),
        .exe_op_class      (exe_op_class),
        .exe_funct3        (exe_funct3),
        .exe_funct7_5      (exe_funct7_5),
        .exe_illegal       (exe_illegal)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] last_exp;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        f75;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mkv(logic [31:0] inst, logic [31:0] pc, logic [31:0] imm,
                                 logic [4:0] rd, logic [2:0] cls, logic [2:0] f3,
                                 logic f75, logic ill, logic [4:0] rs1, logic [4:0] rs2);
        vec_t v;
        v.inst = inst; v.pc = pc; v.imm = imm; v.rd = rd; v.cls = cls;
        v.f3 = f3; v.f75 = f75; v.ill = ill; v.rs1 = rs1; v.rs2 = rs2;
        return v;
    endfunction

    function automatic logic [EXP_W-1:0] pack(logic v, logic [31:0] pc, logic [31:0] d1,
                                              logic [31:0] d2, logic [31:0] imm, logic [4:0] rd,
                                              logic [2:0] cls, logic [2:0] f3, logic f75, logic ill);
        return {v, pc, d1, d2, imm, rd, cls, f3, f75, ill};
    endfunction

    function automatic logic [EXP_W-1:0] cur_out();
        return pack(exe_valid, exe_pc, exe_rs1_data, exe_rs2_data, exe_imm, exe_rd_address,
                    exe_op_class, exe_funct3, exe_funct7_5, exe_illegal);
    endfunction

    // A bubble only guarantees valid, rd and illegal.
    function automatic logic [EXP_W-1:0] bubble_mask();
        return pack(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 5'h1f, 3'd0, 3'd0, 1'b0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        fetch_valid       = v;
        fetch_pc          = pc;
        fetch_instruction = inst;
        rs1_data          = $urandom;
        rs2_data          = $urandom;
        #1;
    endtask

    task automatic expect_vec(input vec_t v);
        logic [EXP_W-1:0] e;
        e = pack(1'b1, v.pc, rs1_data, rs2_data, v.imm, v.rd, v.cls, v.f3, v.f75, v.ill);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic expect_bubble();
        exp_q.push_back(pack(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 3'd0, 1'b0, 1'b0));
    endtask

    // One rising edge, then compare the exe register against the oldest expectation.
    task automatic tick(input string name);
        logic [EXP_W-1:0] e, a, m;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued", name);
        end else begin
            e = exp_q.pop_front();
            a = cur_out();
            m = e[EXP_W-1] ? {EXP_W{1'b1}} : bubble_mask();
            if ((a & m) !== (e & m)) begin
                errors++;
                $display("FAIL %s: got %h expected %h mask %h", name, a, e, m);
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        drive(1'b1, v.pc, v.inst);
        check({name, "_rs1_addr"}, {27'd0, rs1_address}, {27'd0, v.rs1});
        check({name, "_rs2_addr"}, {27'd0, rs2_address}, {27'd0, v.rs2});
        check({name, "_no_stall"}, {31'd0, decode_stall}, 32'd0);
        expect_vec(v);
        tick(name);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t v_lw, v_add, v_lw0, v_add0, v_ill, v_addi;

        vecs[0]  = mkv(32'h00500093, 32'h40, 32'h00000005, 5'd1, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd5);
        vecs[1]  = mkv(32'hFE000EE3, 32'h44, 32'hFFFFFFFC, 5'd0, 3'd3, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        vecs[2]  = mkv(32'h123452B7, 32'h48, 32'h12345000, 5'd5, 3'd6, 3'd5, 1'b0, 1'b0, 5'd8, 5'd3);
        vecs[3]  = mkv(32'h0020A423, 32'h4C, 32'h00000008, 5'd0, 3'd2, 3'd2, 1'b0, 1'b0, 5'd1, 5'd2);
        vecs[4]  = mkv(32'h001000EF, 32'h50, 32'h00000800, 5'd1, 3'd4, 3'd0, 1'b0, 1'b0, 5'd0, 5'd1);
        vecs[5]  = mkv(32'h8000006F, 32'h54, 32'hFFF00000, 5'd0, 3'd4, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        vecs[6]  = mkv(32'hFFF280E7, 32'h58, 32'hFFFFFFFF, 5'd1, 3'd5, 3'd0, 1'b0, 1'b0, 5'd5, 5'd31);
        vecs[7]  = mkv(32'h80000397, 32'h5C, 32'h80000000, 5'd7, 3'd7, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        vecs[8]  = mkv(32'h402081B3, 32'h60, 32'h00000000, 5'd3, 3'd0, 3'd0, 1'b1, 1'b0, 5'd1, 5'd2);
        vecs[9]  = mkv(32'h40325213, 32'h64, 32'h00000403, 5'd4, 3'd0, 3'd5, 1'b1, 1'b0, 5'd4, 5'd3);
        vecs[10] = mkv(32'hFF012303, 32'h68, 32'hFFFFFFF0, 5'd6, 3'd1, 3'd2, 1'b0, 1'b0, 5'd2, 5'd16);
        vecs[11] = mkv(32'h00000F8B, 32'h6C, 32'h00000000, 5'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd0, 5'd0);
        vecs[12] = mkv(32'h00000F81, 32'h70, 32'h00000000, 5'd0, 3'd0, 3'd0, 1'b0, 1'b1, 5'd0, 5'd0);
        vecs[13] = mkv(32'hC000E493, 32'h74, 32'hFFFFFC00, 5'd9, 3'd0, 3'd6, 1'b0, 1'b0, 5'd1, 5'd0);

        v_lw   = mkv(32'h0000A103, 32'h200, 32'h0, 5'd2, 3'd1, 3'd2, 1'b0, 1'b0, 5'd1, 5'd0);
        v_add  = mkv(32'h002101B3, 32'h204, 32'h0, 5'd3, 3'd0, 3'd0, 1'b0, 1'b0, 5'd2, 5'd2);
        v_lw0  = mkv(32'h0000A003, 32'h208, 32'h0, 5'd0, 3'd1, 3'd2, 1'b0, 1'b0, 5'd1, 5'd0);
        v_add0 = mkv(32'h000001B3, 32'h20C, 32'h0, 5'd3, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        v_ill  = mkv(32'hFFFFFFFF, 32'h300, 32'h0, 5'd0, 3'd0, 3'd7, 1'b0, 1'b1, 5'd31, 5'd31);
        v_addi = mkv(32'h00500093, 32'h100, 32'h5, 5'd1, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd5);

        // reset state
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        check("rst_valid", {31'd0, exe_valid}, 32'd0);
        check("rst_pc", exe_pc, RST_PC);
        check("rst_imm", exe_imm, 32'd0);
        check("rst_rd", {27'd0, exe_rd_address}, 32'd0);
        check("rst_illegal", {31'd0, exe_illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // table-driven decode
        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // invalid fetch gives a bubble
        drive(1'b0, 32'h300, 32'h00500093);
        check("invalid_no_stall", {31'd0, decode_stall}, 32'd0);
        expect_bubble();
        tick("invalid_fetch");

        // load-use: lw x2 then add x3,x2,x2
        apply_vec(v_lw, "lw");
        drive(1'b0, v_add.pc, v_add.inst);
        check("hazard_needs_valid", {31'd0, decode_stall}, 32'd0);
        drive(1'b1, v_add.pc, v_add.inst);
        check("load_use_stall", {31'd0, decode_stall}, 32'd1);
        expect_bubble();
        tick("load_use_bubble");
        check("load_use_released", {31'd0, decode_stall}, 32'd0);
        expect_vec(v_add);
        tick("add_after_bubble");

        // load to x0 never stalls
        apply_vec(v_lw0, "lw_x0");
        apply_vec(v_add0, "add_after_lw_x0");

        // illegal, then stall hold, then stall+flush
        apply_vec(v_ill, "illegal");
        stall = 1'b1;
        drive(1'b1, 32'h304, 32'h00500093);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(last_exp);
            tick($sformatf("stall_hold%0d", k));
        end
        flush = 1'b1;
        expect_bubble();
        tick("stall_and_flush");
        stall = 1'b0;

        // flush alone kills the incoming word
        drive(1'b1, 32'h308, 32'h00500093);
        expect_bubble();
        tick("flush_only");
        flush = 1'b0;

        // async reset mid-stream
        apply_vec(v_addi, "pre_reset");
        check("pre_reset_pc", exe_pc, 32'h100);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, exe_valid}, 32'd0);
        check("async_rst_pc", exe_pc, RST_PC);
        check("async_rst_imm", exe_imm, 32'd0);
        check("async_rst_rd", {27'd0, exe_rd_address}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
